// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: default bus widths and
// the arbitration state encoding.
package sram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Round-robin when unlocked, sticky ownership while a requester holds its lock.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic              write0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       rr;
  logic       rr_nxt;
  logic       acc0;
  logic       acc1;
  logic       rd_pend;
  logic       rd_owner;

  // Grants are forced low during reset so nothing is accepted on that edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (!rr) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
          end else begin
            gnt1 = req1;
            gnt0 = req0 & ~req1;
          end
        end
        ST_OWN0: gnt0 = req0;
        ST_OWN1: gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign acc0 = req0 & gnt0;
  assign acc1 = req1 & gnt1;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    case (state)
      ST_IDLE: begin
        if (acc0) begin
          if (lock0) state_nxt = ST_OWN0;
          else       rr_nxt    = 1'b1;
        end else if (acc1) begin
          if (lock1) state_nxt = ST_OWN1;
          else       rr_nxt    = 1'b0;
        end
      end
      ST_OWN0: begin
        if (!lock0) begin
          state_nxt = ST_IDLE;
          rr_nxt    = 1'b1;
        end
      end
      ST_OWN1: begin
        if (!lock1) begin
          state_nxt = ST_IDLE;
          rr_nxt    = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read owner travels with the access so alternating reads return correctly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr          <= 1'b0;
      mem_enable  <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rd_pend     <= 1'b0;
      rd_owner    <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr         <= rr_nxt;
      mem_enable <= acc0 | acc1;
      if (acc1) begin
        mem_address <= addr1;
        mem_write   <= write1;
        mem_wdata   <= wdata1;
      end else if (acc0) begin
        mem_address <= addr0;
        mem_write   <= write0;
        mem_wdata   <= wdata0;
      end else begin
        mem_write   <= 1'b0;
      end
      rd_pend  <= (acc0 & ~write0) | (acc1 & ~write1);
      rd_owner <= acc1;
      rvalid0  <= rd_pend & ~rd_owner;
      rvalid1  <= rd_pend & rd_owner;
    end
  end

  assign rdata0 = rvalid0 ? mem_rdata : '0;
  assign rdata1 = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a
// scoreboard that pairs each accepted read with its rvalid pulse.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, lock0, write0, req1, lock1, write1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [8:0]  mem_address;
  logic        mem_enable, mem_write;
  logic [15:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic        owner;
    logic [15:0] data;
    int          due;
  } rd_t;
  rd_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cnt++;

  sram_port_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .lock1(lock1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous SRAM: word i starts as 16'hA000 | i, read data one cycle after enable.
  logic [15:0] sram [512];
  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 16'hA000 | 16'(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_enable === 1'b1) begin
        if (mem_write) sram[mem_address] = mem_wdata;
        else           mem_rdata <= sram[mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid0 && rvalid1) begin
        checks++;
        errors++;
        $display("FAIL both_rvalid actual=11 expected=one-hot (t=%0t)", $time);
      end else if (rvalid0 || rvalid1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual=owner%0d expected=none (t=%0t)", rvalid1, $time);
        end else begin
          rd_t e;
          e = exp_q.pop_front();
          chk("rvalid_owner", 32'(rvalid1), 32'(e.owner));
          chk("rdata", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.data));
          chk("rvalid_latency", 32'(cnt), 32'(e.due));
        end
      end else begin
        chk("rdata0_idle", 32'(rdata0), 32'h0);
        chk("rdata1_idle", 32'(rdata1), 32'h0);
      end
    end
  end

  task automatic drive(input logic r0, input logic l0, input logic w0, input logic [8:0] a0,
                       input logic [15:0] d0, input logic r1, input logic l1, input logic w1,
                       input logic [8:0] a1, input logic [15:0] d1);
    req0 = r0; lock0 = l0; write0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; write1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // One cycle: inputs already driven; check grants, queue the read, advance.
  task automatic cyc(input string name, input logic eg0, input logic eg1,
                     input logic [15:0] er, input bit push);
    @(negedge clk);
    chk({name, "_gnt0"}, 32'(gnt0), 32'(eg0));
    chk({name, "_gnt1"}, 32'(gnt1), 32'(eg1));
    if (push && ((eg0 && !write0) || (eg1 && !write1))) begin
      rd_t e;
      e.owner = eg1;
      e.data  = er;
      e.due   = cnt + 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(1, 0, 0, 9'h003, '0, 1, 0, 0, 9'h004, '0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'h0);
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_mem_enable", 32'(mem_enable), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1), 32'h0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Round-robin alternation starting with requester 0.
    drive(1, 0, 0, 9'h020, '0, 1, 0, 0, 9'h021, '0);
    cyc("rr1", 1, 0, 16'hA020, 1);
    cyc("rr2", 0, 1, 16'hA021, 1);
    cyc("rr3", 1, 0, 16'hA020, 1);
    cyc("rr4", 0, 1, 16'hA021, 1);

    // Single read by 0 at 0x005, then inspect the SRAM command cycle.
    drive(1, 0, 0, 9'h005, '0, 0, 0, 0, '0, '0);
    cyc("rd5", 1, 0, 16'hA005, 1);
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rd5_mem_enable", 32'(mem_enable), 32'h1);
    chk("rd5_mem_address", 32'(mem_address), 32'h005);
    chk("rd5_mem_write", 32'(mem_write), 32'h0);
    @(posedge clk);
    #1;
    idle_cycles(1);
    @(negedge clk);
    chk("idle_mem_enable", 32'(mem_enable), 32'h0);
    @(posedge clk);
    #1;

    // rr now points at 1: requester 1 locks for 4 reads while 0 waits.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 9'h040, '0, 1, 1, 0, 9'(9'h030 + i), '0);
      cyc("lock", 0, 1, 16'(16'hA030 + i), 1);
    end
    drive(1, 0, 0, 9'h040, '0, 0, 0, 0, '0, '0);
    cyc("unlock", 0, 0, '0, 1);
    cyc("after_unlock", 1, 0, 16'hA040, 1);

    // Interleaved reads on consecutive cycles.
    drive(1, 0, 0, 9'h010, '0, 0, 0, 0, '0, '0);
    cyc("il0", 1, 0, 16'hA010, 1);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 9'h011, '0);
    cyc("il1", 0, 1, 16'hA011, 1);
    drive(1, 0, 0, 9'h012, '0, 0, 0, 0, '0, '0);
    cyc("il2", 1, 0, 16'hA012, 1);

    // Write then read-back through the other requester.
    drive(1, 0, 1, 9'h1FF, 16'hBEEF, 0, 0, 0, '0, '0);
    cyc("wr", 1, 0, '0, 1);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 9'h1FF, '0);
    cyc("rdback", 0, 1, 16'hBEEF, 1);
    idle_cycles(4);

    // Reset one cycle after an accepted read cancels it and clears rr.
    drive(1, 0, 0, 9'h007, '0, 0, 0, 0, '0, '0);
    cyc("pre_rst", 1, 0, '0, 0);
    reset = 1'b0;
    drive(1, 0, 0, 9'h008, '0, 1, 0, 0, 9'h009, '0);
    cyc("in_rst_a", 0, 0, '0, 0);
    @(negedge clk);
    chk("mid_rst_mem_enable", 32'(mem_enable), 32'h0);
    chk("mid_rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("mid_rst_gnt0", 32'(gnt0), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("post_rst", 1, 0, 16'hA008, 1);
    idle_cycles(5);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, the SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, the SRAM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (asserted when 0, sampled on clk).
REQ-005 SHALL have ports reqK, input, 1, requester K (K=0,1) wants one SRAM access this cycle.
REQ-006 SHALL have ports lockK, input, 1, requester K asks to keep ownership after the current access.
REQ-007 SHALL have ports writeK, input, 1, access is a write (1) or a read (0).
REQ-008 SHALL have ports addrK, input, ADDR_W, word address of the access.
REQ-009 SHALL have ports wdataK, input, DATA_W, write data.
REQ-010 SHALL have ports gntK, output, 1, combinational grant; the access is accepted on the edge where reqK and gntK are both 1.
REQ-011 SHALL have ports rvalidK, output, 1, one-cycle pulse marking read data for requester K.
REQ-012 SHALL have ports rdataK, output, DATA_W, read data; it is meaningful only while rvalidK is 1.
REQ-013 SHALL have port mem_address, output, ADDR_W, registered SRAM address.
REQ-014 SHALL have port mem_enable, output, 1, registered SRAM enable.
REQ-015 SHALL have port mem_write, output, 1, registered SRAM write strobe.
REQ-016 SHALL have port mem_wdata, output, DATA_W, registered SRAM write data.
REQ-017 SHALL have port mem_rdata, input, DATA_W, SRAM read data, valid one cycle after a read enable.

Function
REQ-018 SHALL implement an FSM with states IDLE, OWN0 and OWN1; IDLE means unlocked arbitration.
REQ-019 In IDLE, SHALL grant by round-robin pointer rr: the requester equal to rr wins if requesting, otherwise the other requester wins if requesting.
REQ-020 At most one gnt SHALL be 1 in any cycle, and gntK SHALL be 0 whenever reqK is 0.
REQ-021 On an accepted access by K without lockK, SHALL set rr to the other requester and stay in or return to IDLE.
REQ-022 On an accepted access by K with lockK=1, SHALL enter OWNK.
REQ-023 In OWNK, SHALL grant only K; the other requester SHALL wait regardless of rr.
REQ-024 In OWNK, SHALL return to IDLE, with rr set to the other requester, on the first cycle where lockK=0, whether or not K requests in that cycle; an access by K in that cycle is still granted.
REQ-025 An access accepted on edge t SHALL drive mem_enable=1, mem_address, mem_write and mem_wdata during cycle t+1.
REQ-026 mem_enable SHALL be 0 in any cycle following an edge with no accepted access.
REQ-027 For an accepted read, rvalidK SHALL be 1 in cycle t+2 with rdataK=mem_rdata; reads give a throughput of one per cycle with latency 2.
REQ-028 A write SHALL never raise rvalid.
REQ-029 rdataK SHALL be driven 0 when rvalidK=0.
REQ-030 The identity of the read owner SHALL be pipelined alongside the access, so that back-to-back reads by alternating requesters return to the correct requester.

Reset
REQ-031 While reset=0, SHALL force the state to IDLE, rr=0, and mem_enable, mem_write, mem_address, mem_wdata, rvalid0 and rvalid1 to 0.
REQ-032 Reset SHALL cancel in-flight accesses: no rvalid pulse appears for accesses accepted before reset, and gnt0 and gnt1 SHALL be 0 while reset=0.

Structure
REQ-033 SHALL place the state encoding (IDLE, OWN0, OWN1) and the default ADDR_W and DATA_W in a shared package used by the accelerator top.
REQ-034 SHALL be a single module with no sub-module; the grant logic is small enough to stay inline.

Verification
REQ-035 Bench SHALL check this case: after reset, req0=req1=1 continuously with locks=0 -> grants alternate 0,1,0,1..., starting with 0.
REQ-036 Bench SHALL check this case: req0 read at addr 0x005 accepted on edge t -> mem_enable=1 and mem_address=0x005 in cycle t+1; rvalid0=1 with the SRAM word in t+2; rvalid1 stays 0.
REQ-037 Bench SHALL check this case: req1 asserts lock1 for 4 reads while req0 is held -> gnt0=0 for all 4; gnt0=1 on the first cycle after lock1 drops.
REQ-038 Bench SHALL check this case: interleaved reads 0@0x010, 1@0x011, 0@0x012 on consecutive cycles -> rvalid pulses are 0, 1, 0 on consecutive cycles, each with the matching data.
REQ-039 Bench SHALL check this case: write by 0 of 0xBEEF to 0x1FF, then read by 1 of 0x1FF -> rdata1=0xBEEF, and no rvalid for the write.
REQ-040 Bench SHALL check this case: reset=0 asserted one cycle after a read is accepted -> no rvalid appears, mem_enable=0, and the next grant after release goes to requester 0.
